pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock shared with the fetch/decode pipeline registers.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_instr  input  32  instruction currently held in the IF/ID register; opcode [31:26], rs [25:21], rt [20:16].
REQ-005 ex_mem_read  input  1  instruction in EX is a load (lw).
REQ-006 ex_rt  input  5  destination register of the instruction in EX.
REQ-007 branch_taken  input  1  taken branch resolved in EX this cycle.
REQ-008 imem_ready  input  1  instruction memory has valid data this cycle.
REQ-009 resume  input  1  single-cycle pulse that releases HALT.
REQ-010 pc_write  output  1  PC update enable.
REQ-011 if_id_write  output  1  IF/ID register load enable.
REQ-012 if_id_flush  output  1  forces IF/ID to NOP (32'h0) at the next edge.
REQ-013 id_ex_bubble  output  1  forces the ID/EX control fields to NOP.
REQ-014 halted  output  1  high while the FSM is in HALT.
REQ-015 stall_count  output  16  saturating count of stall cycles.
REQ-016 flush_count  output  16  saturating count of taken-branch flush events.

Function
REQ-017 The FSM SHALL have exactly three states, RUN, FLUSH and HALT, held in a state register updated on the rising edge of clock.
REQ-018 The outputs other than the counters SHALL be combinational in the current state and current inputs.
REQ-019 A load-use hazard SHALL be detected when all of the following hold:
- ex_mem_read=1
- ex_rt!=0
- ex_rt==rs, or ex_rt==rt with opcode one of 000000, 101011, 000100 or 000101.
REQ-020 A halt instruction SHALL be opcode 6'b111111 in id_instr.
REQ-021 RUN SHALL evaluate its conditions in this priority order, highest first:
- (a) branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1; go to FLUSH; flush_count+1.
- (b) imem_ready=0: pc_write=0, if_id_write=0, id_ex_bubble=1; stay in RUN; stall_count+1.
- (c) load-use hazard: pc_write=0, if_id_write=0, id_ex_bubble=1; stay in RUN; stall_count+1.
- (d) halt instruction: pc_write=0, if_id_write=0, id_ex_bubble=1; go to HALT.
- (e) otherwise: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-022 A load-use stall SHALL last exactly one cycle, because the bubble inserted into EX removes the hazard on the following cycle.
REQ-023 FLUSH (second wrong-path slot) SHALL drive if_id_flush=1, id_ex_bubble=1, if_id_write=0 and pc_write=imem_ready.
REQ-024 FLUSH SHALL go to RUN when imem_ready=1 and stay in FLUSH otherwise, and SHALL ignore branch_taken.
REQ-025 HALT SHALL drive halted=1, pc_write=0, if_id_write=0 and id_ex_bubble=1.
REQ-026 In HALT, branch_taken=1 SHALL take priority over resume and apply the RUN(a) outputs and transition, because an older branch squashes the halt.
REQ-027 In HALT, resume=1 without branch_taken SHALL set if_id_flush=1 (discarding the halt instruction), keep pc_write=0, and go to RUN.
REQ-028 In HALT with neither branch_taken nor resume, the FSM SHALL stay in HALT.
REQ-029 The counters SHALL saturate at 16'hFFFF and never wrap.
REQ-030 The counters SHALL increment only under the conditions named in REQ-021.
REQ-031 Each counter SHALL increment at most once per cycle.
REQ-032 if_id_flush=1 SHALL take precedence over if_id_write for the IF/ID register.

Reset
REQ-033 While reset=1 the outputs SHALL be: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, halted=0.
REQ-034 At a clock edge with reset=1 the block SHALL load state=RUN, stall_count=0 and flush_count=0.
REQ-035 Reset asserted in any state, including mid-FLUSH or in HALT, SHALL override all other inputs at that edge.

Verification
REQ-036 Scenario: ex_mem_read=1, ex_rt=5, id_instr=32'h00A61020 (rs=5) -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1; pc_write=1 on the next cycle.
REQ-037 Scenario: branch_taken=1 with a hazard also present -> if_id_flush=1 for 2 consecutive cycles; flush_count=1; stall_count unchanged.
REQ-038 Scenario: id_instr=32'hFC000000 -> halted=1 from the next cycle; pc_write=0 held for 10 cycles; resume pulse -> if_id_flush=1 for one cycle, then RUN with pc_write=1.
REQ-039 Scenario: in FLUSH with imem_ready=0 for 3 cycles -> remain in FLUSH with if_id_flush=1; exit to RUN on the cycle after imem_ready=1.
REQ-040 Scenario: stall_count preloaded to 16'hFFFE by forcing 65534 stall cycles, then 3 more stall cycles -> stall_count=16'hFFFF, no wrap.
REQ-041 Scenario: reset asserted while in HALT with stall_count=7 -> at the next edge halted=0, state=RUN, stall_count=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the fetch/decode pipeline (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if;
    logic [31:0] id_instr;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        imem_ready;
    logic        resume;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        halted;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output id_instr, ex_mem_read, ex_rt, branch_taken, imem_ready, resume,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, halted,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_instr, ex_mem_read, ex_rt, branch_taken, imem_ready, resume,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, halted,
        output stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and fetch stalls, taken-branch flush, HALT/resume,
// with saturating stall and flush event counters.
module pipe_hazard_ctrl (
    input logic               clock,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_count_q, flush_count_q;
    logic        stall_inc, flush_inc;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;

    logic [5:0] opcode;
    logic [4:0] rs, rt;
    logic       uses_rt, load_use, halt_instr;
    logic       unused_instr_bits;

    assign opcode = bus.id_instr[31:26];
    assign rs     = bus.id_instr[25:21];
    assign rt     = bus.id_instr[20:16];
    assign unused_instr_bits = ^bus.id_instr[15:0];

    // rt is a source operand only for R-type, sw, beq and bne.
    assign uses_rt = (opcode == 6'b000000) || (opcode == 6'b101011) ||
                     (opcode == 6'b000100) || (opcode == 6'b000101);
    assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == rs) || (uses_rt && (bus.ex_rt == rt)));
    assign halt_instr = (opcode == 6'b111111);

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.branch_taken) begin
                        pc_write     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        flush_inc    = 1'b1;
                        state_d      = StFlush;
                    end else if (!bus.imem_ready || load_use) begin
                        id_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                    end else if (halt_instr) begin
                        id_ex_bubble = 1'b1;
                        state_d      = StHalt;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
                StFlush: begin
                    // Second wrong-path slot; waits for fetch before returning to RUN.
                    pc_write     = bus.imem_ready;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (bus.imem_ready) state_d = StRun;
                end
                StHalt: begin
                    halted       = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (bus.branch_taken) begin
                        // An older branch squashes the halt.
                        pc_write    = 1'b1;
                        if_id_flush = 1'b1;
                        flush_inc   = 1'b1;
                        state_d     = StFlush;
                    end else if (bus.resume) begin
                        if_id_flush = 1'b1;
                        state_d     = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StRun;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_count_q != 16'hFFFF)) stall_count_q <= stall_count_q + 16'd1;
            if (flush_inc && (flush_count_q != 16'hFFFF)) flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.halted       = halted;
    assign bus.stall_count  = stall_count_q;
    assign bus.flush_count  = flush_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // iw < 0 marks if_id_write as don't-care (masked by if_id_flush).
    task automatic chk_ctl(input string tag, input int pw, input int iw, input int fl,
                           input int bb, input int hl);
        check({tag, ".pc_write"}, {31'd0, bus.pc_write}, pw);
        if (iw >= 0) check({tag, ".if_id_write"}, {31'd0, bus.if_id_write}, iw);
        check({tag, ".if_id_flush"}, {31'd0, bus.if_id_flush}, fl);
        check({tag, ".id_ex_bubble"}, {31'd0, bus.id_ex_bubble}, bb);
        check({tag, ".halted"}, {31'd0, bus.halted}, hl);
    endtask

    task automatic chk_cnt(input string tag, input int st, input int fc);
        check({tag, ".stall_count"}, {16'd0, bus.stall_count}, st);
        check({tag, ".flush_count"}, {16'd0, bus.flush_count}, fc);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        bus.id_instr = 32'h0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rt = 5'd0;
        bus.branch_taken = 1'b0;
        bus.imem_ready = 1'b1;
        bus.resume = 1'b0;

        tick(); #1 chk_ctl("reset", 0, 0, 1, 1, 0);
        tick(); reset = 1'b0; #1 chk_ctl("run0", 1, 1, 0, 0, 0);
        chk_cnt("run0", 0, 0);

        // Load-use on rs
        tick(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_instr = 32'h00A61020;
        #1 chk_ctl("lu_rs", 0, 0, 0, 1, 0);
        chk_cnt("lu_rs", 0, 0);
        tick(); bus.ex_mem_read = 1'b0;
        #1 chk_ctl("lu_rs_after", 1, 1, 0, 0, 0);
        chk_cnt("lu_rs_after", 1, 0);

        // Load-use on rt of sw
        tick(); bus.ex_mem_read = 1'b1; bus.id_instr = 32'hAC250000;
        #1 chk_ctl("lu_sw_rt", 0, 0, 0, 1, 0);
        // addi does not read rt
        tick(); bus.id_instr = 32'h20250000;
        #1 chk_ctl("addi_rt", 1, 1, 0, 0, 0);
        chk_cnt("addi_rt", 2, 0);
        // ex_rt = 0 never hazards
        tick(); bus.ex_rt = 5'd0; bus.id_instr = 32'h0;
        #1 chk_ctl("rt_zero", 1, 1, 0, 0, 0);
        tick(); bus.ex_mem_read = 1'b0;

        // Instruction memory not ready
        bus.imem_ready = 1'b0;
        #1 chk_ctl("imem_stall", 0, 0, 0, 1, 0);
        tick(); bus.imem_ready = 1'b1;
        #1 chk_cnt("imem_stall", 3, 0);

        // Branch beats a simultaneous load-use hazard
        bus.branch_taken = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5;
        bus.id_instr = 32'h00A61020;
        #1 chk_ctl("br_hz", 1, -1, 1, 1, 0);
        tick(); bus.branch_taken = 1'b0; bus.ex_mem_read = 1'b0;
        #1 chk_ctl("br_flush2", 1, 0, 1, 1, 0);
        chk_cnt("br_flush2", 3, 1);
        tick(); #1 chk_ctl("br_back", 1, 1, 0, 0, 0);

        // FLUSH waits on imem_ready and ignores branch_taken
        bus.branch_taken = 1'b1;
        tick(); bus.branch_taken = 1'b0; bus.imem_ready = 1'b0;
        #1 chk_ctl("fl_wait1", 0, 0, 1, 1, 0);
        tick(); bus.branch_taken = 1'b1;
        #1 chk_ctl("fl_wait2", 0, 0, 1, 1, 0);
        tick(); bus.branch_taken = 1'b0;
        #1 chk_ctl("fl_wait3", 0, 0, 1, 1, 0);
        chk_cnt("fl_wait3", 3, 2);
        tick(); bus.imem_ready = 1'b1;
        #1 chk_ctl("fl_exit", 1, 0, 1, 1, 0);
        tick(); #1 chk_ctl("fl_run", 1, 1, 0, 0, 0);
        chk_cnt("fl_run", 3, 2);

        // HALT and resume
        bus.id_instr = 32'hFC000000;
        #1 chk_ctl("halt_dec", 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick(); #1 chk_ctl($sformatf("halt_hold%0d", i), 0, 0, 0, 1, 1);
        end
        chk_cnt("halt_hold", 3, 2);
        tick(); bus.resume = 1'b1;
        #1 chk_ctl("resume", 0, 0, 1, 1, 1);
        tick(); bus.resume = 1'b0; bus.id_instr = 32'h0;
        #1 chk_ctl("resume_run", 1, 1, 0, 0, 0);

        // Branch squashes HALT even with resume asserted
        bus.id_instr = 32'hFC000000;
        tick(); bus.branch_taken = 1'b1; bus.resume = 1'b1;
        #1 chk_ctl("halt_br", 1, -1, 1, 1, 1);
        tick(); bus.branch_taken = 1'b0; bus.resume = 1'b0; bus.id_instr = 32'h0;
        #1 chk_ctl("halt_br_flush", 1, 0, 1, 1, 0);
        tick(); #1 chk_ctl("halt_br_run", 1, 1, 0, 0, 0);

        // Reset mid-FLUSH
        bus.branch_taken = 1'b1;
        tick(); bus.branch_taken = 1'b0; bus.imem_ready = 1'b0; reset = 1'b1;
        #1 chk_ctl("rst_flush", 0, 0, 1, 1, 0);
        tick(); reset = 1'b0; bus.imem_ready = 1'b1;
        #1 chk_ctl("rst_flush_run", 1, 1, 0, 0, 0);
        chk_cnt("rst_flush_run", 0, 0);

        // Reset while halted with stall_count = 7
        bus.imem_ready = 1'b0;
        repeat (7) tick();
        bus.imem_ready = 1'b1; bus.id_instr = 32'hFC000000;
        #1 chk_cnt("pre_halt", 7, 0);
        tick(); bus.id_instr = 32'h0;
        #1 chk_ctl("halt7", 0, 0, 0, 1, 1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        #1 chk_ctl("rst_halt", 1, 1, 0, 0, 0);
        chk_cnt("rst_halt", 0, 0);

        // Stall counter saturation
        bus.imem_ready = 1'b0;
        repeat (65534) @(posedge clock);
        @(negedge clock);
        #1 chk_cnt("sat_fffe", 16'hFFFE, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 chk_cnt("sat_ffff", 16'hFFFF, 0);
        bus.imem_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
